// File: rtl/semafor_pkg.sv
// Shared definitions for the pedestrian-crossing blocks: request FSM states
// and default timing constants for the 12 MHz board clock.
package semafor_pkg;

  localparam int unsigned CLK_HZ              = 12_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 50;  // 20 ms
  localparam int unsigned DEF_LOCKOUT_CYCLES  = 2 * CLK_HZ;   // 2 s
  localparam int unsigned DEF_BLINK_HALF      = CLK_HZ / 2;   // 0.5 s

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    LOCK    = 2'd2
  } req_state_t;

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser plus debounce counter; btn_clean follows the
// synchronised input once it has held a new level for DEBOUNCE_CYCLES samples.
module debounce
  import semafor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_clean
);

  localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_pipe;
  logic          btn_sync;
  logic [CW-1:0] db_cnt;

  assign btn_sync = sync_pipe[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_pipe <= '0;
      db_cnt    <= '0;
      btn_clean <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], btn_raw};
      if (btn_sync == btn_clean) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_MAX) begin
        btn_clean <= ~btn_clean;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/buton_pieton.sv
// Pedestrian request conditioner: debounced press -> latched request held
// until serve, blinking wait indicator, and a post-service lockout window.
module buton_pieton
  import semafor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
  parameter int unsigned BLINK_HALF      = DEF_BLINK_HALF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic serve,
  output logic btn_clean,
  output logic req,
  output logic req_pulse,
  output logic wait_led,
  output logic lockout
);

  localparam int unsigned   LW       = $clog2(LOCKOUT_CYCLES + 1);
  localparam int unsigned   BW       = $clog2(BLINK_HALF + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [BW-1:0] BLK_MAX  = BW'(BLINK_HALF - 1);

  req_state_t    state, state_nxt;
  logic [LW-1:0] lock_cnt, lock_nxt;
  logic [BW-1:0] blink_cnt, blink_nxt;
  logic          led_nxt, pulse_nxt;
  logic          clean_d, rise;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_clean(btn_clean)
  );

  assign rise = btn_clean & ~clean_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lock_cnt  <= '0;
      blink_cnt <= '0;
      clean_d   <= 1'b0;
      req       <= 1'b0;
      req_pulse <= 1'b0;
      wait_led  <= 1'b0;
      lockout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      lock_cnt  <= lock_nxt;
      blink_cnt <= blink_nxt;
      clean_d   <= btn_clean;
      req       <= (state_nxt == PENDING);
      req_pulse <= pulse_nxt;
      wait_led  <= led_nxt;
      lockout   <= (state_nxt == LOCK);
    end
  end

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_cnt;
    blink_nxt = '0;
    led_nxt   = 1'b0;
    pulse_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PENDING;
          pulse_nxt = 1'b1;
          led_nxt   = 1'b1;
        end
      end
      PENDING: begin
        // serve beats a coincident rise; extra rises here are simply absorbed
        if (serve) begin
          state_nxt = LOCK;
          lock_nxt  = LOCK_MAX;
        end else if (blink_cnt == BLK_MAX) begin
          led_nxt = ~wait_led;
        end else begin
          led_nxt   = wait_led;
          blink_nxt = blink_cnt + 1'b1;
        end
      end
      LOCK: begin
        if (lock_cnt == '0) state_nxt = IDLE;
        else                lock_nxt  = lock_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_buton_pieton.sv
// Directed bench for buton_pieton with a cycle-level reference model and
// hand-computed checkpoints for press, bounce, serve, lockout and reset.
module tb_buton_pieton;

  localparam int DB = 4;
  localparam int LO = 10;
  localparam int BH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;
  logic serve = 1'b0;
  logic btn_clean, req, req_pulse, wait_led, lockout;

  int total = 0;
  int bad   = 0;

  buton_pieton #(
    .DEBOUNCE_CYCLES(DB),
    .LOCKOUT_CYCLES (LO),
    .BLINK_HALF     (BH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .serve    (serve),
    .btn_clean(btn_clean),
    .req      (req),
    .req_pulse(req_pulse),
    .wait_led (wait_led),
    .lockout  (lockout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: run-length debounce, pending flag with age, lockout
  // cycles remaining. Outputs derived arithmetically below.
  bit m_s1 = 0, m_s2 = 0, m_clean = 0, m_clean_d = 0, m_rise = 0;
  bit m_pend = 0, m_pulse = 0;
  int m_run = 0, m_age = 0, m_lock_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_clean = 0; m_clean_d = 0; m_run = 0;
      m_pend = 0; m_age = 0; m_lock_left = 0; m_pulse = 0;
    end else begin
      m_rise  = m_clean && !m_clean_d;
      m_pulse = 0;
      if (m_pend) begin
        if (serve) begin m_pend = 0; m_lock_left = LO; end
        else m_age++;
      end else if (m_lock_left > 0) begin
        m_lock_left--;
      end else if (m_rise) begin
        m_pend = 1; m_age = 0; m_pulse = 1;
      end
      m_clean_d = m_clean;
      if (m_s2 != m_clean) begin
        m_run++;
        if (m_run == DB) begin m_clean = !m_clean; m_run = 0; end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
  end

  always @(negedge clk) begin
    chk("cmp_clean",   btn_clean, m_clean);
    chk("cmp_req",     req,       m_pend);
    chk("cmp_pulse",   req_pulse, m_pulse);
    chk("cmp_wait",    wait_led,  m_pend && ((m_age / BH) % 2 == 0));
    chk("cmp_lockout", lockout,   m_lock_left > 0);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_clean"},   btn_clean, 1'b0);
    chk({nm, "_req"},     req,       1'b0);
    chk({nm, "_pulse"},   req_pulse, 1'b0);
    chk({nm, "_wait"},    wait_led,  1'b0);
    chk({nm, "_lockout"}, lockout,   1'b0);
  endtask

  int bl_lvl [6] = '{1, 0, 1, 0, 1, 0};
  int bl_len [6] = '{1, 2, 2, 2, 3, 5};
  bit wait_pat [7] = '{1, 1, 1, 0, 0, 0, 1};

  initial begin
    tick(3);
    chk_all_zero("reset");
    rst = 1'b0;
    tick(2);

    // bounce: pulses shorter than the debounce window
    for (int i = 0; i < 6; i++) begin
      btn_raw = bl_lvl[i][0];
      for (int j = 0; j < bl_len[i]; j++) begin
        tick(1);
        chk("bounce_clean", btn_clean, 1'b0);
        chk("bounce_req",   req,       1'b0);
        chk("bounce_pulse", req_pulse, 1'b0);
      end
    end
    tick(4);

    // clean press sampled at edge N
    btn_raw = 1'b1;
    tick(5);                       // after N+4
    chk("press_clean_n4", btn_clean, 1'b0);
    tick(1);                       // after N+5
    chk("press_clean_n5", btn_clean, 1'b1);
    chk("press_req_n5",   req,       1'b0);
    tick(1);                       // after N+6
    chk("press_req_n6",   req,       1'b1);
    chk("press_pulse_n6", req_pulse, 1'b1);
    chk("press_wait_0",   wait_led,  wait_pat[0]);
    tick(1);
    chk("press_pulse_n7", req_pulse, 1'b0);
    chk("press_wait_1",   wait_led,  wait_pat[1]);
    for (int i = 2; i < 7; i++) begin
      tick(1);
      chk("press_wait", wait_led, wait_pat[i]);
    end

    // release, then serve
    btn_raw = 1'b0;
    tick(8);
    serve = 1'b1;
    tick(1);                       // after edge S
    serve = 1'b0;
    chk("serve_req",     req,      1'b0);
    chk("serve_wait",    wait_led, 1'b0);
    chk("serve_lockout", lockout,  1'b1);

    // press debounced inside the lockout window
    btn_raw = 1'b1;
    for (int i = 1; i < LO; i++) begin
      tick(1);
      chk("lock_hold", lockout, 1'b1);
      chk("lock_req",  req,     1'b0);
    end
    tick(1);
    chk("lock_end", lockout, 1'b0);
    tick(4);
    chk("lock_discard_req", req, 1'b0);

    // release and re-press after lockout
    btn_raw = 1'b0;
    tick(8);
    btn_raw = 1'b1;
    tick(6);
    chk("repress_req_n5", req, 1'b0);
    tick(1);
    chk("repress_req_n6",   req,       1'b1);
    chk("repress_pulse_n6", req_pulse, 1'b1);
    tick(1);
    chk("repress_pulse_n7", req_pulse, 1'b0);

    // second press while pending: no extra strobe
    btn_raw = 1'b0;
    tick(8);
    btn_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("second_pulse", req_pulse, 1'b0);
      chk("second_req",   req,       1'b1);
    end

    // rise and serve on the same edge while pending
    btn_raw = 1'b0;
    tick(8);
    btn_raw = 1'b1;
    tick(6);
    serve = 1'b1;
    tick(1);
    serve = 1'b0;
    chk("simul_req",     req,       1'b0);
    chk("simul_pulse",   req_pulse, 1'b0);
    chk("simul_lockout", lockout,   1'b1);
    chk("simul_wait",    wait_led,  1'b0);
    tick(12);
    chk("simul_after_lock", lockout, 1'b0);
    chk("simul_after_req",  req,     1'b0);

    // async reset mid-pending
    btn_raw = 1'b0;
    tick(8);
    btn_raw = 1'b1;
    tick(8);
    chk("pre_rst_req", req, 1'b1);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    tick(2);
    rst = 1'b0;
    tick(6);
    chk("post_rst_req_n5", req, 1'b0);
    tick(1);
    chk("post_rst_req_n6",   req,       1'b1);
    chk("post_rst_pulse_n6", req_pulse, 1'b1);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/buton_pieton.md
# buton_pieton

Pedestrian request conditioner that sits directly upstream of the traffic-light controller and drives its `btn` input. It synchronises and debounces the raw push-button and converts a press into a clean request level. That level holds until the controller reports that the pedestrian phase has been served. It also drives a blinking "wait" indicator and applies a post-service lockout so repeated presses cannot immediately re-trigger the cycle.

## Interface
- `DEBOUNCE_CYCLES`, default 240000: cycles the synchronised input must stay at a new level before `btn_clean` follows it (20 ms at 12 MHz); must be ≥1.
- `LOCKOUT_CYCLES`, default 24000000: cycles after `serve` during which new presses are ignored (2 s at 12 MHz); must be ≥1.
- `BLINK_HALF`, default 6000000: half-period of `wait_led` in cycles (0.5 s at 12 MHz); must be ≥1.
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  reset, asynchronous, active-high; all state is cleared immediately on assertion.
- `btn_raw`  in  1  raw button, asynchronous to `clk`, bouncy, 1 = pressed.
- `serve`  in  1  one-cycle pulse from the controller when the pedestrian-green phase begins.
- `btn_clean`  out  1  debounced button level.
- `req`  out  1  latched pedestrian request; connects to the controller `btn`.
- `req_pulse`  out  1  one-cycle strobe on each accepted request.
- `wait_led`  out  1  blinking "request registered" indicator.
- `lockout`  out  1  high while the post-service lockout is running.

## Operation
- **Synchroniser:** two flops on `btn_raw` produce `btn_sync`. Both flops reset to 0.
- **Debounce:**
  - The counter `db_cnt` has width $clog2(DEBOUNCE_CYCLES+1).
  - It clears whenever `btn_sync == btn_clean`.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 and the inputs still differ, `btn_clean` toggles and the counter clears.
  - A bounce shorter than DEBOUNCE_CYCLES produces no output change.
- **Edge detect:** `rise` = `btn_clean` AND NOT (`btn_clean` delayed one cycle).
- **Request FSM** has three states:
  - IDLE → PENDING on `rise`. On that edge: `req` := 1, `req_pulse` := 1 for one cycle.
  - PENDING → LOCK on `serve`. On that edge: `req` := 0, lockout counter loads LOCKOUT_CYCLES-1. Further `rise` events in PENDING are absorbed, with no extra `req_pulse`.
  - LOCK → IDLE when the lockout counter is 0 and decrementing ends. `rise` in LOCK is discarded, not remembered.
  - `serve` received in IDLE or LOCK is ignored. In LOCK it does not reload the counter.
- **Simultaneous `rise` and `serve`:** both in PENDING → `serve` wins and the state goes to LOCK. Both in IDLE → the `rise` is accepted and the state goes to PENDING.
- **`wait_led`:**
  - 0 unless the state is PENDING.
  - On entry to PENDING it is 1, then it toggles every BLINK_HALF cycles.
  - Its counter clears on leaving PENDING.
- **`lockout`** = (state == LOCK).
- **Reset values:** `btn_clean`=0, `req`=0, `req_pulse`=0, `wait_led`=0, `lockout`=0, state IDLE, all counters 0. Reset mid-operation drops any pending request and any lockout.

## Timing
- All outputs are registered.
- A clean `btn_raw` rising edge sampled at clock edge N gives:
  - `btn_sync` high after edge N+1;
  - `btn_clean` high after edge N+1+DEBOUNCE_CYCLES;
  - `req` and `req_pulse` high after edge N+2+DEBOUNCE_CYCLES.
- `req` falls on the edge that samples `serve`=1. `lockout` rises on that same edge and stays high for exactly LOCKOUT_CYCLES cycles.
- The first `rise` accepted after lockout is the one in the cycle where the state is IDLE.
- `wait_led` period is 2·BLINK_HALF cycles, phase-aligned to the `req` rising edge.

## Structure
- Shared package `semafor_pkg`:
  - request FSM state enum (IDLE, PENDING, LOCK);
  - default timing constants for the 12 MHz clock, shared with the controller durations.
- One natural sub-module, `debounce`: synchroniser plus debounce counter, parameterised by DEBOUNCE_CYCLES, outputs `btn_clean`. It is reusable for other board buttons.
- The request FSM, blink counter and lockout counter live in the top.

## Test plan
Benches use DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=10, BLINK_HALF=3.
- **Clean press.** `btn_raw` goes 0→1 and is held, sampled at edge 0 → `btn_clean`=1 after edge 5; `req`=1 and `req_pulse`=1 after edge 6; `req_pulse`=0 after edge 7; `wait_led` pattern 1,1,1,0,0,0,1…
- **Bounce.** `btn_raw` pulses of 1–3 cycles separated by lows → `btn_clean`, `req` and `req_pulse` stay 0.
- **Serve.** After `req`=1, pulse `serve` → `req`=0 and `wait_led`=0 on that edge; `lockout`=1 for exactly 10 cycles.
- **Press in lockout.** A press debounced inside the lockout window → no `req`. A release, then a new press after `lockout`=0 → `req`=1 with one `req_pulse`.
- **Simultaneous.** `rise` and `serve` in the same cycle while PENDING → state LOCK, `req`=0, no `req_pulse`. A second press while PENDING → no second pulse.
- **Async reset.** Assert `rst` mid-PENDING, between clock edges → all outputs 0 immediately. After release, a press is accepted with normal latency.
